// File: rtl/connect4_turn_ctrl.sv
// Connect-4 turn sequencer: validates column drops, issues one board write per legal move,
// then samples the board's win flag to pass the turn or end the game.
module connect4_turn_ctrl #(
    parameter int ROWS        = 6,
    parameter int COLS        = 7,
    parameter int ADDR_BASE   = 11,
    parameter int ADDR_STRIDE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       drop_valid,
    input  logic [2:0] drop_col,
    output logic       drop_ready,
    output logic       reject,
    output logic [2:0] colval,
    output logic [4:0] waddr,
    output logic       Player,
    input  logic       winflag,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw,
    output logic [5:0] move_count
);

    typedef enum logic [1:0] {IDLE, WRITE, CHECK, OVER} state_t;

    localparam logic [2:0] NO_COL    = 3'd7;
    localparam logic [2:0] FULL_COL  = 3'(ROWS);
    localparam logic [2:0] BOTTOM    = 3'(ROWS - 1);
    localparam logic [5:0] ALL_MOVES = 6'(ROWS * COLS);

    state_t     state;
    state_t     state_next;
    logic [2:0] height [COLS];
    logic [2:0] col_q;
    logic [2:0] sel_height;
    logic [2:0] land_row;
    logic [4:0] land_addr;
    logic       col_ok;
    logic       legal;
    logic       take;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take && legal) state_next = WRITE;
            WRITE:   state_next = CHECK;
            CHECK:   state_next = (winflag || move_count == ALL_MOVES) ? OVER : IDLE;
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    // An out-of-range column reads as a full column, so a single test covers both illegal cases.
    always_comb begin
        sel_height = FULL_COL;
        col_ok     = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            if (int'(drop_col) == i) begin
                sel_height = height[i];
                col_ok     = 1'b1;
            end
        end
        legal      = col_ok && (sel_height != FULL_COL);
        drop_ready = (state == IDLE);
        take       = drop_ready && drop_valid;
        land_row   = BOTTOM - sel_height;
        land_addr  = 5'(ADDR_BASE + ADDR_STRIDE * int'(land_row));
    end

    // colval is loaded on acceptance so it is valid exactly during WRITE and parked at 7 otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < COLS; i++) begin
                height[i] <= 3'd0;
            end
            col_q      <= 3'd0;
            colval     <= NO_COL;
            waddr      <= 5'd0;
            reject     <= 1'b0;
            Player     <= 1'b1;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            draw       <= 1'b0;
            move_count <= 6'd0;
        end else begin
            reject <= take && !legal;
            colval <= NO_COL;
            case (state)
                IDLE: begin
                    if (take && legal) begin
                        col_q  <= drop_col;
                        colval <= drop_col;
                        waddr  <= land_addr;
                    end
                end
                WRITE: begin
                    for (int i = 0; i < COLS; i++) begin
                        if (int'(col_q) == i && height[i] != FULL_COL) begin
                            height[i] <= height[i] + 3'd1;
                        end
                    end
                    move_count <= move_count + 6'd1;
                end
                CHECK: begin
                    // A win on the last free cell is still a win, never a draw.
                    if (winflag) begin
                        winner    <= Player ? 2'b01 : 2'b10;
                        game_over <= 1'b1;
                    end else if (move_count == ALL_MOVES) begin
                        draw      <= 1'b1;
                        game_over <= 1'b1;
                    end else begin
                        Player <= ~Player;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/connect4_turn_ctrl.md
# connect4_turn_ctrl

Turn sequencer for the Connect-4 datapath. It accepts column-drop requests from the input front end and rejects illegal ones. For each legal move it computes the landing row, drives one write cycle (`colval`, `waddr`, `Player`) into the board and win-check block, and samples `winflag` the next cycle. It then either passes the turn or ends the game with a winner or a draw.

## Interface
Parameters:
- `ROWS`, 6: board rows; row 0 is the top, row `ROWS-1` is the bottom.
- `COLS`, 7: board columns.
- `ADDR_BASE`, 11: `waddr` of row 0.
- `ADDR_STRIDE`, 4: `waddr` increment per row.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `drop_valid`  in  1  move request.
- `drop_col`  in  3  requested column.
- `drop_ready`  out  1  controller can accept a request.
- `reject`  out  1  one-cycle pulse: the last accepted request was illegal.
- `colval`  out  3  write column to the board; 7 means no write.
- `waddr`  out  5  write address to the board; equals `ADDR_BASE + ADDR_STRIDE*row`.
- `Player`  out  1  side to move: 1 writes piece 1, 0 writes piece 2.
- `winflag`  in  1  combinational win indication from the board.
- `game_over`  out  1  game has ended; held until reset.
- `winner`  out  2  01 = player 1, 10 = player 2, 00 = none.
- `draw`  out  1  board full with no win.
- `move_count`  out  6  number of legal moves written.

## Operation
States:
- `IDLE`: `drop_ready`=1. On `drop_valid`, the request is taken.
  - If `drop_col>=COLS` or `height[drop_col]==ROWS`: pulse `reject`, stay in `IDLE`.
  - Otherwise latch the column and row `ROWS-1-height[col]`, then go to `WRITE`.
- `WRITE`: one cycle. `colval` = latched column, `waddr` = computed address, `Player` held stable. At the end of the cycle, increment `height[col]` and `move_count`. Go to `CHECK`.
- `CHECK`: one cycle. `colval`=7, and `winflag` is sampled.
  - `winflag`=1: `winner` = `Player ? 01 : 10`, `game_over`=1, go to `OVER`; `Player` is not toggled.
  - Else if `move_count==ROWS*COLS`: `draw`=1, `game_over`=1, go to `OVER`.
  - Else: toggle `Player`, go to `IDLE`.
- `OVER`: `drop_ready`=0, `colval`=7. All outputs hold. Only reset exits this state.

Other rules:
- Column heights are `COLS` 3-bit counters, each saturating at `ROWS`.
- `waddr` is computed in 5 bits. Default row range gives 11..31; no wrap occurs.
- A win on the final (42nd) move reports `winner`; `draw` stays 0. The win check has priority.
- `drop_valid` outside `IDLE` is ignored and not queued.
- `colval` is 7 in every state except `WRITE`, so the board never sees a spurious write.
- This block does not clear board storage. A new game requires the board to be cleared externally at reset.

## Timing
Reset values (when `rst`=0 at an edge):
- state `IDLE`, all heights 0, `move_count` 0, `Player`=1
- `colval`=7, `waddr`=0, `reject`=0, `game_over`=0, `winner`=00, `draw`=0

Reset rules:
- Reset overrides every state, including mid-`WRITE` and `OVER`.
- The first cycle after reset release is `IDLE` with `drop_ready`=1.

Legal move, accepted at edge N (`IDLE`):
- `WRITE` is cycle N+1; the board captures the piece at the end of that cycle.
- `CHECK` is cycle N+2.
- `Player` toggle, or `game_over`/`winner`, is visible from cycle N+3.
- `drop_ready` returns high in cycle N+3. Throughput is one move per 3 cycles.

Illegal move, accepted at edge N:
- `reject`=1 during cycle N+1 only.
- `drop_ready` stays 1. Heights, `move_count` and `Player` are unchanged.

All outputs are registered except `drop_ready`, which decodes the state.

## Test plan
- After reset, check the idle outputs. Then alternate drops: player 1 in column 0, player 2 in column 1, for 7 moves.
  - `waddr` on the player-1 writes: 31, 27, 23, 19.
  - After the 7th move, `winner`=01, `game_over`=1, `move_count`=7, `Player`=1.
- Drop into column 2 seven times.
  - First six writes: `waddr` = 31, 27, 23, 19, 15, 11.
  - Seventh request: `reject` pulses, no `WRITE` state, `move_count`=6.
- `drop_col`=7: `reject`=1 for one cycle, `colval` stays 7, `Player` unchanged.
- A bench-generated 42-move sequence that a model confirms is win-free gives `draw`=1, `winner`=00, `move_count`=42, `drop_ready`=0.
- Assert `rst`=0 in the `WRITE` cycle of the 3rd move. The next cycle shows `IDLE`, `colval`=7, `move_count`=0, `Player`=1, and all heights 0 (the next drop into that column gives `waddr`=31).
- Hold `drop_valid` during `WRITE`/`CHECK` with a different column: exactly one move is written per handshake, and the held request is taken only on return to `IDLE`.
